wb_port_arbiter: RTL and testbench

Shares the single register-file write port between the in-order pipeline write-back stage and a long-latency result source, such as a multi-cycle divider or a load-return path. The block sits between the W-stage result selection and the register file.
- Pipeline writes always win and pass through combinationally.
- Long-latency results are buffered in a small FIFO and drained in idle write-port cycles.
- A starvation timer requests a pipeline bubble when buffered results wait too long.
- A pending-destination mask lets the hazard unit stall readers of registers whose results are still buffered.

---
 rtl/wb_port_arbiter.sv | 156 +++++++++++++++
 tb/tb_wb_port_arbiter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between the pipeline
// W stage (absolute priority, combinational pass-through) and a buffered
// long-latency result source drained in idle port cycles.
//
// state   | meaning
// IDLE    | no bubble requested
// STARVED | FIFO head starved too long, StallReq asserted until it pops
module wb_port_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RegWriteW,
  input  logic [4:0]  RdW,
  input  logic [31:0] ResultW,
  input  logic        LLValid,
  input  logic [4:0]  LLRd,
  input  logic [31:0] LLData,
  output logic        LLReady,
  output logic        RegWriteRF,
  output logic [4:0]  RdRF,
  output logic [31:0] WDataRF,
  output logic [31:0] PendingMask,
  output logic        StallReq
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [SC_W-1:0]  SC_MAX   = SC_W'(STARVE_LIMIT);

  typedef enum logic {IDLE = 1'b0, STARVED = 1'b1} state_t;

  logic [PTR_W-1:0] r_rptr;
  logic [PTR_W-1:0] r_wptr;
  logic [CNT_W-1:0] r_count;
  logic [SC_W-1:0]  r_starve_cnt;
  state_t           r_state;
  state_t           w_state_nxt;

  logic [4:0]       r_rd   [DEPTH];
  logic [31:0]      r_data [DEPTH];

  logic             w_pipe_req;
  logic             w_empty;
  logic             w_pop;
  logic             w_accept;
  logic             w_push;
  logic [DEPTH-1:0] w_entry_valid;
  logic [31:0]      w_pending;

  assign w_pipe_req = RegWriteW & (RdW != 5'd0);
  assign w_empty    = (r_count == '0);
  // The FIFO only gets the port when the pipeline leaves it idle.
  assign w_pop      = ~w_empty & ~w_pipe_req;
  assign LLReady    = (r_count != FULL_CNT);
  assign w_accept   = LLValid & LLReady;
  // Results aimed at x0 complete the handshake but are never stored.
  assign w_push     = w_accept & (LLRd != 5'd0);

  // Write-port mux: pipeline first, then FIFO head, else idle.
  always_comb begin
    RegWriteRF = 1'b0;
    RdRF       = 5'd0;
    WDataRF    = 32'd0;
    if (w_pipe_req) begin
      RegWriteRF = 1'b1;
      RdRF       = RdW;
      WDataRF    = ResultW;
    end else if (!w_empty) begin
      RegWriteRF = 1'b1;
      RdRF       = r_rd[r_rptr];
      WDataRF    = r_data[r_rptr];
    end
  end

  // FIFO storage; contents need no reset since validity comes from the count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_rd[r_wptr]   <= LLRd;
      r_data[r_wptr] <= LLData;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (w_pop && !w_push) r_count <= r_count - CNT_W'(1);
    end
  end

  // An entry is live if its distance from the read pointer is below the count.
  always_comb begin
    w_entry_valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_entry_valid[i] = (CNT_W'(PTR_W'(PTR_W'(i) - r_rptr)) < r_count);
    end
  end

  // Pending-destination mask: OR of one-hot Rd decodes of live entries.
  always_comb begin
    w_pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_entry_valid[i]) w_pending[r_rd[i]] = 1'b1;
    end
  end

  assign PendingMask = w_pending;

  // Starvation timer: counts head denials, cleared by a pop or an empty FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve_cnt <= '0;
    end else if (w_empty || w_pop) begin
      r_starve_cnt <= '0;
    end else if (w_pipe_req && (r_starve_cnt != SC_MAX)) begin
      r_starve_cnt <= r_starve_cnt + SC_W'(1);
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if ((r_starve_cnt == SC_MAX) && !w_pop && !w_empty) w_state_nxt = STARVED;
      end
      STARVED: begin
        if (w_pop || w_empty) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM outputs; StallReq comes straight from the state flop.
  always_comb begin
    StallReq = (r_state == STARVED);
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter (DEPTH=2, STARVE_LIMIT=4).
// Inputs change at the falling edge; outputs are checked 1ns later.
module tb_wb_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        RegWriteW;
  logic [4:0]  RdW;
  logic [31:0] ResultW;
  logic        LLValid;
  logic [4:0]  LLRd;
  logic [31:0] LLData;
  logic        LLReady;
  logic        RegWriteRF;
  logic [4:0]  RdRF;
  logic [31:0] WDataRF;
  logic [31:0] PendingMask;
  logic        StallReq;

  int tests;
  int fails;

  wb_port_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .RegWriteW  (RegWriteW),
    .RdW        (RdW),
    .ResultW    (ResultW),
    .LLValid    (LLValid),
    .LLRd       (LLRd),
    .LLData     (LLData),
    .LLReady    (LLReady),
    .RegWriteRF (RegWriteRF),
    .RdRF       (RdRF),
    .WDataRF    (WDataRF),
    .PendingMask(PendingMask),
    .StallReq   (StallReq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge (one rising edge in between).
  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic pipe(input logic we, input logic [4:0] rd, input logic [31:0] d);
    RegWriteW = we;
    RdW       = rd;
    ResultW   = d;
  endtask

  task automatic ll(input logic v, input logic [4:0] rd, input logic [31:0] d);
    LLValid = v;
    LLRd    = rd;
    LLData  = d;
  endtask

  task automatic chk_rf(input string tag, input logic we, input logic [4:0] rd, input logic [31:0] d);
    chk({tag, "_we"}, 32'(RegWriteRF), 32'(we));
    chk({tag, "_rd"}, 32'(RdRF), 32'(rd));
    chk({tag, "_wd"}, WDataRF, d);
  endtask

  initial begin
    logic seen;
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    pipe(1'b0, 5'd0, 32'd0);
    ll(1'b0, 5'd0, 32'd0);

    // Reset state; write port follows the pipeline even in reset.
    nxt(); #1;
    chk("rst_llready", 32'(LLReady), 32'd1);
    chk("rst_mask", PendingMask, 32'd0);
    chk("rst_stall", 32'(StallReq), 32'd0);
    chk_rf("rst_idle", 1'b0, 5'd0, 32'd0);
    pipe(1'b1, 5'd5, 32'h0000_0ABC); #1;
    chk_rf("rst_pipe", 1'b1, 5'd5, 32'h0000_0ABC);
    pipe(1'b0, 5'd0, 32'd0);
    nxt();
    rst_n = 1'b1;

    // Pipeline pass-through, and x0 suppression.
    nxt(); pipe(1'b1, 5'd5, 32'h0000_1234); #1;
    chk_rf("pipe5", 1'b1, 5'd5, 32'h0000_1234);
    pipe(1'b1, 5'd0, 32'h0000_1234); #1;
    chk_rf("pipe_x0", 1'b0, 5'd0, 32'd0);

    // Single long-latency result with idle pipeline.
    nxt(); pipe(1'b0, 5'd0, 32'd0); ll(1'b1, 5'd7, 32'hDEAD_BEEF); #1;
    chk("ll1_ready", 32'(LLReady), 32'd1);
    chk_rf("ll1_nobypass", 1'b0, 5'd0, 32'd0);
    nxt(); ll(1'b0, 5'd0, 32'd0); #1;
    chk_rf("ll1_write", 1'b1, 5'd7, 32'hDEAD_BEEF);
    chk("ll1_mask", PendingMask, 32'h0000_0080);
    nxt(); #1;
    chk("ll1_mask_clr", PendingMask, 32'd0);
    chk_rf("ll1_empty", 1'b0, 5'd0, 32'd0);

    // Fill and starve: pipeline writes x1 every cycle.
    nxt(); pipe(1'b1, 5'd1, 32'h1111_1111); ll(1'b1, 5'd3, 32'h0000_0033); #1;
    chk("fill0_ready", 32'(LLReady), 32'd1);
    nxt(); ll(1'b1, 5'd4, 32'h0000_0044); #1;           // first denial
    chk("fill1_ready", 32'(LLReady), 32'd1);
    chk_rf("fill1_pipe", 1'b1, 5'd1, 32'h1111_1111);
    chk("fill1_mask", PendingMask, 32'h0000_0008);
    nxt(); ll(1'b0, 5'd0, 32'd0); #1;
    chk("full_ready", 32'(LLReady), 32'd0);
    chk("full_mask", PendingMask, 32'h0000_0018);
    chk("starve_c2", 32'(StallReq), 32'd0);
    nxt(); #1; chk("starve_c3", 32'(StallReq), 32'd0);
    nxt(); #1; chk("starve_c4", 32'(StallReq), 32'd0);
    nxt(); #1; chk("starve_c5", 32'(StallReq), 32'd0);
    nxt(); #1; chk("starve_c6", 32'(StallReq), 32'd1);
    nxt(); pipe(1'b0, 5'd0, 32'd0); #1;                 // bubble
    chk_rf("bubble_x3", 1'b1, 5'd3, 32'h0000_0033);
    chk("bubble_stall", 32'(StallReq), 32'd1);
    nxt(); #1;
    chk("after_pop_stall", 32'(StallReq), 32'd0);
    chk("after_pop_ready", 32'(LLReady), 32'd1);
    chk("after_pop_mask", PendingMask, 32'h0000_0010);
    chk_rf("drain_x4", 1'b1, 5'd4, 32'h0000_0044);
    nxt(); #1;
    chk_rf("drained", 1'b0, 5'd0, 32'd0);
    chk("drained_mask", PendingMask, 32'd0);

    // Simultaneous push and pop at count=1.
    nxt(); ll(1'b1, 5'd9, 32'h0000_0099);
    nxt(); ll(1'b1, 5'd10, 32'h0000_00AA); #1;
    chk_rf("pp_x9", 1'b1, 5'd9, 32'h0000_0099);
    chk("pp_ready", 32'(LLReady), 32'd1);
    chk("pp_mask9", PendingMask, 32'h0000_0200);
    nxt(); ll(1'b0, 5'd0, 32'd0); #1;
    chk_rf("pp_x10", 1'b1, 5'd10, 32'h0000_00AA);
    chk("pp_mask10", PendingMask, 32'h0000_0400);
    nxt(); #1;
    chk_rf("pp_empty", 1'b0, 5'd0, 32'd0);

    // x0 discard while one entry (x2) is buffered behind a busy pipeline.
    nxt(); pipe(1'b1, 5'd1, 32'h1); ll(1'b1, 5'd2, 32'h0000_0022);
    nxt(); ll(1'b1, 5'd0, 32'h0000_0055); #1;
    chk("x0_ready", 32'(LLReady), 32'd1);
    nxt(); ll(1'b0, 5'd0, 32'd0); #1;
    chk("x0_mask", PendingMask, 32'h0000_0004);
    chk("x0_count_ready", 32'(LLReady), 32'd1);
    nxt(); pipe(1'b0, 5'd0, 32'd0); #1;
    chk_rf("x0_drain_x2", 1'b1, 5'd2, 32'h0000_0022);
    nxt(); #1;
    chk_rf("x0_nowrite", 1'b0, 5'd0, 32'd0);

    // Reset mid-operation with a full FIFO and StallReq high.
    nxt(); pipe(1'b1, 5'd1, 32'h1); ll(1'b1, 5'd11, 32'h0000_00BB);
    nxt(); ll(1'b1, 5'd12, 32'h0000_00CC);
    nxt(); ll(1'b0, 5'd0, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      nxt(); #1;
      if (StallReq === 1'b1) seen = 1'b1;
    end
    chk("mid_starve_wait", 32'(seen), 32'd1);
    chk("mid_full", 32'(LLReady), 32'd0);
    #1 rst_n = 1'b0; #1;
    chk("mid_rst_ready", 32'(LLReady), 32'd1);
    chk("mid_rst_mask", PendingMask, 32'd0);
    chk("mid_rst_stall", 32'(StallReq), 32'd0);
    chk_rf("mid_rst_pipe", 1'b1, 5'd1, 32'h1);
    nxt(); rst_n = 1'b1; pipe(1'b0, 5'd0, 32'd0); #1;
    chk_rf("post_rst0", 1'b0, 5'd0, 32'd0);
    nxt(); #1;
    chk_rf("post_rst1", 1'b0, 5'd0, 32'd0);
    chk("post_rst_mask", PendingMask, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
